// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the SIPS4 multiply/divide sequencer: ALU op codes,
// flag bit positions and the sequencer state encoding.
package alu_muldiv_seq_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int FLAG_C = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 4x4 multiply (shift-add) and 4/4 divide (restoring) that
// borrows the shared execute-stage ALU for the add/subtract of every step.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_div,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags
);

    localparam int STEPS = W;
    localparam logic [1:0] CNT_LAST = 2'(STEPS - 1);

    state_t state, state_next;
    logic [1:0] cnt;

    // hi/lo double as {product high, multiplier} or {remainder, quotient};
    // opnd holds the multiplicand or the divisor.
    logic [W-1:0] hi, lo, opnd;
    logic         is_div;

    logic         accept, div_zero, launch, running, last_step;
    logic         carry, take;
    logic [W-1:0] p;
    logic [W-1:0] hi_next, lo_next;
    logic         unused_flags;

    assign unused_flags = ^alu_flags[3:1];

    assign running   = (state == ST_RUN);
    assign busy      = running;
    assign accept    = (state == ST_IDLE) && start;
    assign div_zero  = accept && op_div && (opb == '0);
    assign launch    = accept && !div_zero;
    assign last_step = running && (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (launch)    state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    assign p = {hi[W-2:0], lo[W-1]};

    // ALU is driven only while running; idle leaves it at ADD 0+0 for the parent.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (running) begin
            if (is_div) begin
                alu_op = ALU_SUB;
                alu_a  = p;
                alu_b  = opnd;
            end else begin
                alu_op = ALU_ADD;
                alu_a  = hi;
                alu_b  = lo[0] ? opnd : '0;
            end
        end
    end

    // A set rem MSB means the shifted partial remainder is >= 16 > divisor, so the
    // wrapped 4-bit subtract result is exact even though the ALU reports a borrow.
    assign carry = alu_flags[FLAG_C];
    assign take  = hi[W-1] | ~carry;

    always_comb begin
        if (is_div) begin
            hi_next = take ? alu_result : p;
            lo_next = {lo[W-2:0], take};
        end else begin
            hi_next = {carry, alu_result[W-1:1]};
            lo_next = {alu_result[0], lo[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            hi     <= '0;
            lo     <= op_div ? opa : opb;
            opnd   <= op_div ? opb : opa;
            is_div <= op_div;
        end else if (running) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (div_zero) begin
                done   <= 1'b1;
                err    <= 1'b1;
                res_hi <= opa;
                res_lo <= '1;
            end else if (launch) begin
                err <= 1'b0;
                cnt <= '0;
            end
            if (running) begin
                cnt <= cnt + 2'd1;
                if (last_step) begin
                    done   <= 1'b1;
                    res_hi <= hi_next;
                    res_lo <= lo_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ALU, directed corner cases,
// exhaustive operand sweeps and random operations against an arithmetic model.
module tb_alu_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op_div;
    logic [3:0] opa, opb;
    logic       busy, done, err;
    logic [3:0] res_hi, res_lo;
    logic [3:0] alu_op, alu_a, alu_b, alu_result, alu_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_div     (op_div),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    // Shared SIPS4 ALU, reduced to ADD/SUB with carry/borrow in flags[0].
    logic [4:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    always_comb begin
        alu_result = alu_sum[3:0];
        alu_flags  = {3'b000, alu_sum[4]};
        if (alu_op == 4'b0001) begin
            alu_result = alu_a - alu_b;
            alu_flags  = {3'b000, (alu_a < alu_b)};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {err, res_hi, res_lo} as the operation is defined arithmetically.
    function automatic logic [8:0] model(input logic d, input logic [3:0] a, input logic [3:0] b);
        int prod;
        if (d) begin
            if (b == 0) return {1'b1, a, 4'hF};
            return {1'b0, 4'(a % b), 4'(a / b)};
        end
        prod = int'(a) * int'(b);
        return {1'b0, 4'(prod / 16), 4'(prod % 16)};
    endfunction

    // Issues one op and stops at the negedge where done is seen (or budget expires).
    task automatic do_op(input logic d, input logic [3:0] a, input logic [3:0] b,
                         output logic [8:0] got, output int bc, output bit ok);
        @(negedge clk);
        start = 1'b1; op_div = d; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; op_div = 1'($urandom); opa = 4'($urandom); opb = 4'($urandom);
        bc = 0; ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        got = {err, res_hi, res_lo};
    endtask

    task automatic check_op(input string tag, input logic d, input logic [3:0] a, input logic [3:0] b);
        logic [8:0] got;
        int bc;
        bit ok;
        do_op(d, a, b, got, bc, ok);
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_res"}, 32'(got), 32'(model(d, a, b)));
        chk({tag, "_busy_cycles"}, 32'(bc), (d && b == 0) ? 32'd0 : 32'd4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] got;
        int bc;
        bit ok;
        logic [3:0] ra, rb;
        logic rd;
        bit saw_done;

        rst_n = 1'b0; start = 1'b0; op_div = 1'b0; opa = '0; opb = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_res", 32'({res_hi, res_lo}), 32'd0);
        chk("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 15*15 with timing and ALU release at done.
        do_op(1'b0, 4'hF, 4'hF, got, bc, ok);
        chk("mul15x15_done_seen", 32'(ok), 32'd1);
        chk("mul15x15_res", 32'(got), 32'h0E1);
        chk("mul15x15_busy_cycles", 32'(bc), 32'd4);
        chk("mul15x15_busy_at_done", 32'(busy), 32'd0);
        chk("idle_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("res_hold", 32'({res_hi, res_lo}), 32'hE1);

        check_op("mul0x9", 1'b0, 4'd0, 4'd9);
        check_op("mul9x0", 1'b0, 4'd9, 4'd0);
        check_op("div13_3", 1'b1, 4'd13, 4'd3);
        check_op("div15_1", 1'b1, 4'd15, 4'd1);
        check_op("div2_7", 1'b1, 4'd2, 4'd7);

        // Divide by zero: immediate done, busy never raised.
        do_op(1'b1, 4'd9, 4'd0, got, bc, ok);
        chk("div9_0_done_seen", 32'(ok), 32'd1);
        chk("div9_0_res", 32'(got), 32'h19F);
        chk("div9_0_busy_cycles", 32'(bc), 32'd0);
        check_op("err_cleared", 1'b0, 4'd3, 4'd5);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                check_op("mul_sweep", 1'b0, 4'(a), 4'(b));
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                check_op("div_sweep", 1'b1, 4'(a), 4'(b));

        // Start pulsed mid-run with different operands is ignored.
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; opa = 4'd7; opb = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; opa = 4'd14; opb = 4'd3;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("ignore_done_seen", 32'(ok), 32'd1);
        chk("ignore_res", 32'({err, res_hi, res_lo}), 32'h03F);
        @(negedge clk);
        chk("ignore_not_queued", 32'(busy), 32'd0);

        // Back-to-back: start raised in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; opa = 4'd11; opb = 4'd4;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("b2b_first_seen", 32'(ok), 32'd1);
        chk("b2b_first_res", 32'({err, res_hi, res_lo}), 32'h032);
        start = 1'b1; op_div = 1'b0; opa = 4'd6; opb = 4'd13;
        @(negedge clk);
        start = 1'b0;
        bc = 0; ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin ok = 1'b1; break; end
            if (busy) bc++;
            @(negedge clk);
        end
        chk("b2b_second_seen", 32'(ok), 32'd1);
        chk("b2b_second_res", 32'({err, res_hi, res_lo}), 32'h04E);
        chk("b2b_second_busy", 32'(bc), 32'd4);

        // Async reset mid-operation after an err result so every output has something to clear.
        check_op("pre_abort_div0", 1'b1, 4'd9, 4'd0);
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; opa = 4'd7; opb = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_res", 32'({res_hi, res_lo}), 32'd0);
        chk("abort_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        check_op("after_abort", 1'b1, 4'd13, 4'd3);

        for (int i = 0; i < 200; i++) begin
            rd = 1'($urandom);
            ra = 4'($urandom);
            rb = 4'($urandom_range(0, 15));
            check_op(rd ? "rand_div" : "rand_mul", rd, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
